// File: rtl/game2048_pkg.sv
// Shared encodings for the 2048 engine: one-hot FSM states, move directions,
// the empty-cell exponent and the LFSR tap positions.
package game2048_pkg;

  // Bit order matches the debug state port {LOSE,WIN,CHECK,SPAWN,SHIFT,WAIT,INIT}.
  typedef enum logic [6:0] {
    ST_INIT  = 7'b0000001,
    ST_WAIT  = 7'b0000010,
    ST_SHIFT = 7'b0000100,
    ST_SPAWN = 7'b0001000,
    ST_CHECK = 7'b0010000,
    ST_WIN   = 7'b0100000,
    ST_LOSE  = 7'b1000000
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int EXP_EMPTY = 0;

  localparam int LFSR_TAP_A = 16;
  localparam int LFSR_TAP_B = 14;
  localparam int LFSR_TAP_C = 13;
  localparam int LFSR_TAP_D = 11;

endpackage

// File: rtl/game2048_line_merge.sv
// Combinational slide-and-merge of one board line; index 0 is the edge the
// tiles move toward.
module game2048_line_merge
  import game2048_pkg::*;
#(
  parameter int N       = 4,
  parameter int EXP_W   = 4,
  parameter int WIN_EXP = 11,
  parameter int ADD_W   = 20
) (
  input  logic [N*EXP_W-1:0] line_i,
  output logic [N*EXP_W-1:0] line_o,
  output logic               changed_o,
  output logic [ADD_W-1:0]   score_add_o,
  output logic               win_hit_o
);

  localparam logic [EXP_W-1:0] EMPTY   = EXP_W'(EXP_EMPTY);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] WIN_E   = EXP_W'(WIN_EXP);

  // One spare slot past the end keeps the pair compare in range on the last tile.
  logic [EXP_W-1:0] comp [N+1];
  logic [EXP_W-1:0] res  [N];

  always_comb begin
    int  fill;
    int  put;
    logic skip;
    for (int i = 0; i <= N; i++) comp[i] = EMPTY;
    for (int i = 0; i < N; i++) res[i] = EMPTY;
    fill        = 0;
    put         = 0;
    skip        = 1'b0;
    score_add_o = '0;
    win_hit_o   = 1'b0;
    line_o      = '0;

    for (int i = 0; i < N; i++) begin
      if (line_i[i*EXP_W +: EXP_W] != EMPTY) begin
        comp[fill] = line_i[i*EXP_W +: EXP_W];
        fill++;
      end
    end

    // A merged tile consumes its partner, so the next slot is skipped.
    for (int i = 0; i < N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != EMPTY) begin
        if ((comp[i] == comp[i+1]) && (comp[i] != EXP_MAX)) begin
          res[put]    = comp[i] + 1'b1;
          score_add_o = score_add_o + (ADD_W'(1) << (int'(comp[i]) + 1));
          if (res[put] == WIN_E) win_hit_o = 1'b1;
          skip = 1'b1;
        end else begin
          res[put] = comp[i];
        end
        put++;
      end
    end

    for (int i = 0; i < N; i++) line_o[i*EXP_W +: EXP_W] = res[i];
    changed_o = (line_o != line_i);
  end

endmodule

// File: rtl/game2048_core.sv
// N x N 2048 engine: board of tile exponents, one line merged per SHIFT cycle,
// LFSR-driven tile spawning, saturating score and win/lose detection.
module game2048_core
  import game2048_pkg::*;
#(
  parameter int          N          = 4,
  parameter int          EXP_W      = 4,
  parameter int          WIN_EXP    = 11,
  parameter int          SCORE_W    = 20,
  parameter int          INIT_TILES = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         RC_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               ld_en,
  input  logic [RC_W-1:0]    ld_row,
  input  logic [RC_W-1:0]    ld_col,
  input  logic [EXP_W-1:0]   ld_exp,
  input  logic [RC_W-1:0]    rd_row,
  input  logic [RC_W-1:0]    rd_col,
  output logic [EXP_W-1:0]   rd_exp,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               moved,
  output logic               win,
  output logic               lose,
  output logic [6:0]         state
);

  localparam int NN      = N * N;
  localparam int IDX_W   = (NN > 1) ? $clog2(NN) : 1;
  localparam int CNT_W   = IDX_W + 1;
  localparam int BOARD_W = NN * EXP_W;
  localparam logic [EXP_W-1:0] EMPTY   = EXP_W'(EXP_EMPTY);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  state_e               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [15:0]          lfsr_q;
  dir_e                 dir_q, dir_d;
  logic [RC_W-1:0]      k_q, k_d;
  logic                 changed_q, changed_d;
  logic                 winhit_q, winhit_d;
  logic                 moved_q, moved_d;
  logic [CNT_W-1:0]     spawn_cnt_q, spawn_cnt_d;
  logic [CNT_W-1:0]     tested_q, tested_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic                 lfsr_fb;
  logic [IDX_W-1:0]     seed_ptr;
  logic [EXP_W-1:0]     spawn_exp;
  logic [N*EXP_W-1:0]   line_in, line_out;
  logic                 line_changed, line_win;
  logic [SCORE_W-1:0]   score_add;
  logic [SCORE_W:0]     score_sum;
  logic                 scan_alive;

  // Cell index of element j of line k, ordered from the destination edge.
  function automatic int line_cell(input dir_e d, input int k, input int j);
    case (d)
      DIR_LEFT:  return k * N + j;
      DIR_RIGHT: return k * N + (N - 1 - j);
      DIR_UP:    return j * N + k;
      default:   return (N - 1 - j) * N + k;
    endcase
  endfunction

  function automatic logic [EXP_W-1:0] cell_at(input logic [BOARD_W-1:0] b, input int i);
    return b[i*EXP_W +: EXP_W];
  endfunction

  assign lfsr_fb   = lfsr_q[LFSR_TAP_A-1] ^ lfsr_q[LFSR_TAP_B-1] ^
                     lfsr_q[LFSR_TAP_C-1] ^ lfsr_q[LFSR_TAP_D-1];
  assign spawn_exp = (lfsr_q[7:4] == 4'd0) ? EXP_W'(2) : EXP_W'(1);

  always_comb begin
    seed_ptr = lfsr_q[IDX_W-1:0];
    if (int'(seed_ptr) >= NN) seed_ptr = seed_ptr - IDX_W'(NN);
  end

  always_comb begin
    line_in = '0;
    for (int j = 0; j < N; j++)
      line_in[j*EXP_W +: EXP_W] = cell_at(board_q, line_cell(dir_q, int'(k_q), j));
  end

  game2048_line_merge #(
    .N      (N),
    .EXP_W  (EXP_W),
    .WIN_EXP(WIN_EXP),
    .ADD_W  (SCORE_W)
  ) u_merge (
    .line_i     (line_in),
    .line_o     (line_out),
    .changed_o  (line_changed),
    .score_add_o(score_add),
    .win_hit_o  (line_win)
  );

  assign score_sum = {1'b0, score_q} + {1'b0, score_add};

  // CHECK scans cell ptr_q; max-exponent tiles can never pair up.
  always_comb begin
    int i;
    int r;
    int c;
    logic [EXP_W-1:0] e;
    i = int'(ptr_q);
    r = i / N;
    c = i % N;
    e = cell_at(board_q, i);
    scan_alive = (e == EMPTY);
    if (e != EXP_MAX) begin
      if ((c < N - 1) && (e == cell_at(board_q, (c < N - 1) ? i + 1 : i))) scan_alive = 1'b1;
      if ((r < N - 1) && (e == cell_at(board_q, (r < N - 1) ? i + N : i))) scan_alive = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    score_d     = score_q;
    dir_d       = dir_q;
    k_d         = k_q;
    changed_d   = changed_q;
    winhit_d    = winhit_q;
    spawn_cnt_d = spawn_cnt_q;
    ptr_d       = ptr_q;
    tested_d    = tested_q;
    moved_d     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        board_d     = '0;
        score_d     = '0;
        spawn_cnt_d = CNT_W'(INIT_TILES);
        ptr_d       = seed_ptr;
        tested_d    = '0;
        state_d     = ST_SPAWN;
      end
      ST_WAIT: begin
        if (ld_en) begin
          if ((int'(ld_row) < N) && (int'(ld_col) < N))
            board_d[(int'(ld_row) * N + int'(ld_col))*EXP_W +: EXP_W] = ld_exp;
        end else if (up || down || left || right) begin
          dir_d     = up ? DIR_UP : (down ? DIR_DOWN : (left ? DIR_LEFT : DIR_RIGHT));
          k_d       = '0;
          changed_d = 1'b0;
          winhit_d  = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        for (int j = 0; j < N; j++)
          board_d[line_cell(dir_q, int'(k_q), j)*EXP_W +: EXP_W] = line_out[j*EXP_W +: EXP_W];
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        changed_d = changed_q | line_changed;
        winhit_d  = winhit_q | line_win;
        k_d       = k_q + 1'b1;
        if (int'(k_q) == N - 1) begin
          if (winhit_d) begin
            state_d = ST_WIN;
          end else if (changed_d) begin
            moved_d     = 1'b1;
            spawn_cnt_d = CNT_W'(1);
            ptr_d       = seed_ptr;
            tested_d    = '0;
            state_d     = ST_SPAWN;
          end else begin
            ptr_d   = '0;
            state_d = ST_CHECK;
          end
        end
      end
      ST_SPAWN: begin
        if (cell_at(board_q, int'(ptr_q)) == EMPTY) begin
          board_d[int'(ptr_q)*EXP_W +: EXP_W] = spawn_exp;
          spawn_cnt_d = spawn_cnt_q - 1'b1;
          ptr_d       = seed_ptr;
          tested_d    = '0;
          if (spawn_cnt_q <= 1) begin
            ptr_d   = '0;
            state_d = ST_CHECK;
          end
        end else begin
          ptr_d    = (int'(ptr_q) == NN - 1) ? '0 : ptr_q + 1'b1;
          tested_d = tested_q + 1'b1;
          if (int'(tested_q) == NN - 1) begin
            ptr_d   = '0;
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        ptr_d = ptr_q + 1'b1;
        if (scan_alive) state_d = ST_WAIT;
        else if (int'(ptr_q) == NN - 1) state_d = ST_LOSE;
      end
      ST_WIN, ST_LOSE: begin
        if (start) state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      board_q     <= '0;
      score_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      dir_q       <= DIR_UP;
      k_q         <= '0;
      changed_q   <= 1'b0;
      winhit_q    <= 1'b0;
      moved_q     <= 1'b0;
      spawn_cnt_q <= '0;
      tested_q    <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      score_q     <= score_d;
      lfsr_q      <= {lfsr_q[14:0], lfsr_fb};
      dir_q       <= dir_d;
      k_q         <= k_d;
      changed_q   <= changed_d;
      winhit_q    <= winhit_d;
      moved_q     <= moved_d;
      spawn_cnt_q <= spawn_cnt_d;
      tested_q    <= tested_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rd_exp = ((int'(rd_row) < N) && (int'(rd_col) < N)) ?
                  cell_at(board_q, int'(rd_row) * N + int'(rd_col)) : EMPTY;
  assign score  = score_q;
  assign busy   = !((state_q == ST_WAIT) || (state_q == ST_WIN) || (state_q == ST_LOSE));
  assign moved  = moved_q;
  assign win    = (state_q == ST_WIN);
  assign lose   = (state_q == ST_LOSE);
  assign state  = state_q;

endmodule
